// File: rtl/success_detector.sv
// Registered lowest-index priority detector for four controller success flags.
// Reports whether any lane succeeded and which one, one cycle after sampling.
module success_detector (
  input  logic       controller1,
  input  logic       controller2,
  input  logic       controller3,
  input  logic       controller4,
  input  logic       clk,
  output logic [1:0] successfulController,
  output logic       success,
  input  logic       reset
);

  logic       success_q;
  logic       success_d;
  logic [1:0] idx_q;
  logic [1:0] idx_d;

  // Priority-encode the flags; the index holds when no lane is high
  always_comb begin
    success_d = controller1 | controller2
              | controller3 | controller4;
    idx_d     = idx_q;
    priority case (1'b1)
      controller1: idx_d = 2'b00;
      controller2: idx_d = 2'b01;
      controller3: idx_d = 2'b10;
      controller4: idx_d = 2'b11;
      default:     idx_d = idx_q;
    endcase
  end

  // Output registers with synchronous reset overriding the flags
  always_ff @(posedge clk) begin
    if (reset) begin
      success_q <= 1'b0;
      idx_q     <= 2'b00;
    end else begin
      success_q <= success_d;
      idx_q     <= idx_d;
    end
  end

  assign success              = success_q;
  assign successfulController = idx_q;

endmodule

// File: tb/tb_success_detector.sv
// Self-checking bench for success_detector.
// Table-driven vectors feed a scoreboard queue checked after each edge.
module tb_success_detector;

  logic       clk;
  logic       reset;
  logic       c1, c2, c3, c4;
  logic [1:0] idx;
  logic       succ;

  success_detector dut (
    .controller1          (c1),
    .controller2          (c2),
    .controller3          (c3),
    .controller4          (c4),
    .clk                  (clk),
    .successfulController (idx),
    .success              (succ),
    .reset                (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] fl;
    logic       es;
    logic [1:0] ei;
  } vec_t;

  typedef struct packed {
    logic       es;
    logic [1:0] ei;
  } exp_t;

  localparam int NV = 22;
  vec_t tbl [NV];
  exp_t sb [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic es,
                       input logic [1:0] ei);
    checks++;
    if (succ !== es || idx !== ei) begin
      errors++;
      $display("FAIL %s: got success=%b idx=%b, expected success=%b idx=%b",
               nm, succ, idx, es, ei);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] f,
                       input logic es, input logic [1:0] ei);
    exp_t e;
    @(negedge clk);
    reset = r;
    {c4, c3, c2, c1} = f;
    e.es = es;
    e.ei = ei;
    sb.push_back(e);
  endtask

  task automatic collect(input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      check(nm, e.es, e.ei);
    end
  endtask

  initial begin
    reset = 1'b1;
    {c4, c3, c2, c1} = 4'b0000;

    // rst, {c4,c3,c2,c1}, success, index
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 2'b00};
    tbl[1]  = '{1'b0, 4'b0001, 1'b1, 2'b00};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 2'b00};
    tbl[3]  = '{1'b0, 4'b0010, 1'b1, 2'b01};
    tbl[4]  = '{1'b0, 4'b0000, 1'b0, 2'b01};
    tbl[5]  = '{1'b0, 4'b0100, 1'b1, 2'b10};
    tbl[6]  = '{1'b0, 4'b0000, 1'b0, 2'b10};
    tbl[7]  = '{1'b0, 4'b1000, 1'b1, 2'b11};
    tbl[8]  = '{1'b0, 4'b0000, 1'b0, 2'b11};
    tbl[9]  = '{1'b0, 4'b1001, 1'b1, 2'b00};
    tbl[10] = '{1'b0, 4'b1110, 1'b1, 2'b01};
    tbl[11] = '{1'b0, 4'b1111, 1'b1, 2'b00};
    tbl[12] = '{1'b0, 4'b0100, 1'b1, 2'b10};
    tbl[13] = '{1'b0, 4'b0000, 1'b0, 2'b10};
    tbl[14] = '{1'b0, 4'b0000, 1'b0, 2'b10};
    tbl[15] = '{1'b0, 4'b0000, 1'b0, 2'b10};
    tbl[16] = '{1'b0, 4'b0000, 1'b0, 2'b10};
    tbl[17] = '{1'b1, 4'b1000, 1'b0, 2'b00};
    tbl[18] = '{1'b0, 4'b1000, 1'b1, 2'b11};
    tbl[19] = '{1'b0, 4'b1010, 1'b1, 2'b01};
    tbl[20] = '{1'b1, 4'b0000, 1'b0, 2'b00};
    tbl[21] = '{1'b0, 4'b0000, 1'b0, 2'b00};

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].es, tbl[i].ei);
      collect($sformatf("vec%0d", i));
    end

    // Establish a known winner before the glitch test
    drive(1'b0, 4'b1000, 1'b1, 2'b11);
    collect("pre_glitch");
    drive(1'b0, 4'b0000, 1'b0, 2'b11);
    collect("pre_glitch_idle");

    // Glitch on controller2 strictly between edges
    drive(1'b0, 4'b0000, 1'b0, 2'b11);
    #1 c2 = 1'b1;
    #1 check("glitch_mid", 1'b0, 2'b11);
    #1 c2 = 1'b0;
    collect("glitch_edge");
    drive(1'b0, 4'b0000, 1'b0, 2'b11);
    collect("glitch_after");

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/success_detector.md
# success_detector

Registered one-hot-to-index detector at the output stage of the four-controller comparison datapath. Each of four controller lanes raises a single-bit "correct output achieved" flag. The block samples the four flags on every rising clock edge and reports whether any lane succeeded (`success`) and which lane (`successfulController`, 2-bit index). Simultaneous successes are resolved by fixed priority to the lowest-numbered lane.

## Interface
Parameters: none.

Ports, in positional order: controller1, controller2, controller3, controller4, clk, successfulController, success, reset. `reset` is last so existing positional instantiations stay valid.

- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `reset`: input, 1 bit. Synchronous, active-high reset, sampled on the rising edge of `clk`.
- `controller1`: input, 1 bit. Success flag of lane 1 (index 2'b00). Level-sensitive, synchronous to `clk`.
- `controller2`: input, 1 bit. Success flag of lane 2 (index 2'b01).
- `controller3`: input, 1 bit. Success flag of lane 3 (index 2'b10).
- `controller4`: input, 1 bit. Success flag of lane 4 (index 2'b11).
- `successfulController`: output, 2 bits. Registered index of the winning lane.
- `success`: output, 1 bit. Registered; 1 when at least one flag was high at the last sampling edge.

## Operation
- All outputs are registered. No combinational path from inputs to outputs.
- On each rising `clk` edge with `reset`=0:
  - `success` <= controller1 | controller2 | controller3 | controller4.
  - If any flag is high, `successfulController` <= index of the lowest-numbered high flag. Priority order: controller1 > controller2 > controller3 > controller4.
  - If no flag is high, `successfulController` holds its previous value, so it always names the last winner.
- Multiple simultaneous flags:
  - Only the highest-priority lane is reported.
  - No error is flagged.
  - Example: controller2 and controller4 both high -> index 2'b01.
- Inputs are treated as already synchronous to `clk`. No synchronizers or debouncing.

## Timing
- Reset: on a rising edge with `reset`=1, `success`=0 and `successfulController`=2'b00. Reset overrides any flag values in the same cycle.
- Reset asserted mid-operation clears both outputs at the next rising edge. No residual state remains.
- Latency is exactly one cycle. A flag pattern present at edge N appears on the outputs after edge N and stays valid until edge N+1.
- Throughput is one sample per cycle.
- A flag high for one full cycle produces a one-cycle `success` pulse.
- Flags changing between edges have no effect. Only the value at the rising edge matters.
- Before the first clock edge or reset, output values are undefined. A bench must apply `reset` or tolerate X until the first edge.

## Test plan
- Reset: all flags 0, `reset`=1 for one edge -> `success`=0, `successfulController`=2'b00.
- Single-lane sweep: raise controller1, controller2, controller3, controller4 one at a time, each for one clock, with a 0-cycle between each. Required response:
  - `success`=1 with index 00, 01, 10, 11 respectively, one cycle after each flag.
  - `success`=0 on the idle cycles, with the index holding the previous winner.
- Priority: controller1=1 and controller4=1 -> index 00. controller2=controller3=controller4=1 -> index 01. All four = 1 -> index 00, `success`=1.
- Hold: controller3 pulse, then four idle cycles -> `success`=0 for all four idle cycles and `successfulController` stays 2'b10.
- Reset during activity: controller4 held at 1, `reset`=1 for one edge -> outputs 0/00 at that edge. With `reset` released, the next edge gives `success`=1, index 11.
- Glitch immunity: controller2 toggled 0->1->0 between two rising edges -> no change on either output.
